// File: rtl/run_checker.sv
// run_checker: run-control and result-check harness for the SIMD AES core.
// Sequences core reset and a bounded run, then compares register-file reads against a loadable table.
module run_checker #(
   parameter  int DATA_W     = 32,
   parameter  int ADDR_W     = 4,
   parameter  int NUM_CHECKS = 6,
   parameter  int RST_CYCLES = 1,
   parameter  int MAX_CYCLES = 20,
   localparam int IDX_W      = (NUM_CHECKS > 1) ? $clog2(NUM_CHECKS) : 1,
   localparam int ERR_W      = $clog2(NUM_CHECKS + 1),
   localparam int CNT_W      = $clog2(MAX_CYCLES + 1)
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              start,
   input  logic              halt,
   output logic              core_rst,
   output logic              core_en,
   input  logic              exp_we,
   input  logic [IDX_W-1:0]  exp_idx,
   input  logic [ADDR_W-1:0] exp_addr,
   input  logic [DATA_W-1:0] exp_data,
   output logic [ADDR_W-1:0] reg_addr,
   input  logic [DATA_W-1:0] reg_rdata,
   output logic              busy,
   output logic              done,
   output logic              pass,
   output logic              timeout,
   output logic [ERR_W-1:0]  err_count,
   output logic [IDX_W-1:0]  fail_idx,
   output logic [DATA_W-1:0] fail_data,
   output logic [CNT_W-1:0]  cycle_count
);

   // state   | meaning
   // S_IDLE  | core held in reset, waiting for start
   // S_RESET | core reset held for RST_CYCLES cycles
   // S_RUN   | core enabled until halt or run budget expires
   // S_CHECK | core frozen, table entries issued and compared
   // S_DONE  | results valid and held, core frozen

   localparam int PTR_W = $clog2(NUM_CHECKS + 1);
   localparam int RST_W = (RST_CYCLES > 1) ? $clog2(RST_CYCLES) : 1;

   typedef enum logic [2:0] {
      S_IDLE,
      S_RESET,
      S_RUN,
      S_CHECK,
      S_DONE
   } state_t;

   state_t state, state_nxt;

   logic [NUM_CHECKS-1:0] tbl_vld;
   logic [ADDR_W-1:0]     tbl_addr [NUM_CHECKS];
   logic [DATA_W-1:0]     tbl_data [NUM_CHECKS];

   logic [RST_W-1:0] rst_left;
   logic [CNT_W-1:0] run_left;
   logic [PTR_W-1:0] chk_ptr;
   logic [IDX_W-1:0] issue_idx;
   logic [IDX_W-1:0] cmp_idx;
   logic             cmp_vld;
   logic             issuing;
   logic             mismatch;
   logic             tbl_wr;

   assign issue_idx = chk_ptr[IDX_W-1:0];
   assign issuing   = (state == S_CHECK) && (chk_ptr != PTR_W'(NUM_CHECKS));
   assign mismatch  = cmp_vld && tbl_vld[cmp_idx] && (reg_rdata != tbl_data[cmp_idx]);
   assign tbl_wr    = exp_we && !busy && (32'(exp_idx) < NUM_CHECKS);

   assign busy        = (state == S_RESET) || (state == S_RUN) || (state == S_CHECK);
   assign done        = (state == S_DONE);
   assign pass        = done && (err_count == '0) && !timeout;
   assign cycle_count = CNT_W'(MAX_CYCLES) - run_left;

   always_ff @(posedge clk) begin
      if (!rst) state <= S_IDLE;
      else      state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      core_rst  = 1'b1;
      core_en   = 1'b0;
      case (state)
         S_IDLE:  if (start) state_nxt = S_RESET;
         S_RESET: if (rst_left == '0) state_nxt = S_RUN;
         S_RUN: begin
            core_rst = 1'b0;
            core_en  = 1'b1;
            if (halt || run_left == CNT_W'(1)) state_nxt = S_CHECK;
         end
         S_CHECK: begin
            core_rst = 1'b0;
            if (chk_ptr == PTR_W'(NUM_CHECKS)) state_nxt = S_DONE;
         end
         S_DONE: begin
            core_rst = 1'b0;
            if (start) state_nxt = S_RESET;
         end
         default: state_nxt = S_IDLE;
      endcase
   end

   // only entries that were written are driven onto the read port
   always_comb begin
      reg_addr = '0;
      if (issuing && tbl_vld[issue_idx]) reg_addr = tbl_addr[issue_idx];
   end

   always_ff @(posedge clk) begin
      if (!rst)        tbl_vld <= '0;
      else if (tbl_wr) tbl_vld[exp_idx] <= 1'b1;
   end

   always_ff @(posedge clk) begin
      if (tbl_wr) begin
         tbl_addr[exp_idx] <= exp_addr;
         tbl_data[exp_idx] <= exp_data;
      end
   end

   always_ff @(posedge clk) begin
      if (!rst) begin
         rst_left  <= '0;
         run_left  <= CNT_W'(MAX_CYCLES);
         chk_ptr   <= '0;
         cmp_vld   <= 1'b0;
         cmp_idx   <= '0;
         timeout   <= 1'b0;
         err_count <= '0;
         fail_idx  <= '0;
         fail_data <= '0;
      end else begin
         cmp_vld <= 1'b0;
         case (state)
            S_IDLE, S_DONE: begin
               if (start) begin
                  rst_left  <= RST_W'(RST_CYCLES - 1);
                  run_left  <= CNT_W'(MAX_CYCLES);
                  timeout   <= 1'b0;
                  err_count <= '0;
                  fail_idx  <= '0;
                  fail_data <= '0;
               end
            end
            S_RESET: if (rst_left != '0) rst_left <= rst_left - RST_W'(1);
            S_RUN: begin
               run_left <= run_left - CNT_W'(1);
               chk_ptr  <= '0;
               if (!halt && run_left == CNT_W'(1)) timeout <= 1'b1;
            end
            S_CHECK: begin
               if (issuing) begin
                  chk_ptr <= chk_ptr + PTR_W'(1);
                  cmp_vld <= 1'b1;
                  cmp_idx <= issue_idx;
               end
            end
            default: ;
         endcase
         // compare lands one cycle after issue, matching the read-port latency
         if (mismatch) begin
            err_count <= err_count + ERR_W'(1);
            if (err_count == '0) begin
               fail_idx  <= cmp_idx;
               fail_data <= reg_rdata;
            end
         end
      end
   end

endmodule

// File: tb/tb_run_checker.sv
// tb_run_checker: directed bench for run_checker with a synchronous-read register-file model.
// Expected values are hand-computed from the run-control and check rules.
module tb_run_checker;
   localparam int DATA_W     = 32;
   localparam int ADDR_W     = 4;
   localparam int NUM_CHECKS = 6;
   localparam int RST_CYCLES = 1;
   localparam int MAX_CYCLES = 20;

   logic        clk = 1'b0;
   logic        rst = 1'b0;
   logic        start = 1'b0;
   logic        halt = 1'b0;
   logic        exp_we = 1'b0;
   logic [2:0]  exp_idx = '0;
   logic [3:0]  exp_addr = '0;
   logic [31:0] exp_data = '0;
   logic [31:0] reg_rdata = '0;
   logic        core_rst, core_en, busy, done, pass, timeout;
   logic [3:0]  reg_addr;
   logic [2:0]  err_count;
   logic [2:0]  fail_idx;
   logic [31:0] fail_data;
   logic [4:0]  cycle_count;

   logic [31:0] regs [16];
   logic [31:0] exp_vals [6] = '{32'd2, 32'd4, 32'd2, 32'd2, 32'd6, 32'd4};

   int n_chk = 0;
   int n_pass = 0;
   int chk_cyc, addr_cnt, rst_fall, both_hi, first_err, first_cc, first_done;

   always #5 clk = ~clk;

   always @(posedge clk) reg_rdata <= regs[reg_addr];

   run_checker #(
      .DATA_W(DATA_W), .ADDR_W(ADDR_W), .NUM_CHECKS(NUM_CHECKS),
      .RST_CYCLES(RST_CYCLES), .MAX_CYCLES(MAX_CYCLES)
   ) dut (
      .clk(clk), .rst(rst), .start(start), .halt(halt),
      .core_rst(core_rst), .core_en(core_en),
      .exp_we(exp_we), .exp_idx(exp_idx), .exp_addr(exp_addr), .exp_data(exp_data),
      .reg_addr(reg_addr), .reg_rdata(reg_rdata),
      .busy(busy), .done(done), .pass(pass), .timeout(timeout),
      .err_count(err_count), .fail_idx(fail_idx), .fail_data(fail_data),
      .cycle_count(cycle_count)
   );

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_chk++;
      if (got === exp) n_pass++;
      else $display("FAIL %s: got %0d expected %0d", tag, got, exp);
   endtask

   task automatic load(input int idx, input int addr, input int data);
      @(negedge clk);
      exp_we = 1'b1; exp_idx = 3'(idx); exp_addr = 4'(addr); exp_data = 32'(data);
      @(negedge clk);
      exp_we = 1'b0;
   endtask

   // halt_at = RUN cycle (1-based) with halt high, 0 = never
   task automatic do_run(input int halt_at, input bit start_in_run, input bit we_in_run);
      int run_n = 0;
      int guard = 0;
      chk_cyc = 0; addr_cnt = 0; rst_fall = 0; both_hi = 0;
      @(negedge clk); start = 1'b1;
      @(negedge clk); start = 1'b0;
      first_err = int'(err_count); first_cc = int'(cycle_count); first_done = int'(done);
      while (!done && guard < 200) begin
         if (!core_rst && rst_fall == 0) rst_fall = guard + 1;
         if (busy && done) both_hi++;
         if (core_en) begin
            run_n++;
            if (run_n == halt_at) halt = 1'b1;
            if (start_in_run && run_n == 3) start = 1'b1;
            if (we_in_run && run_n == 5) begin
               exp_we = 1'b1; exp_idx = 3'd0; exp_addr = 4'd1; exp_data = 32'd99;
            end
         end
         if (busy && !core_en && !core_rst) begin
            chk_cyc++;
            if (reg_addr != 4'd0) addr_cnt++;
         end
         @(negedge clk);
         halt = 1'b0; start = 1'b0; exp_we = 1'b0;
         guard++;
      end
      if (busy && done) both_hi++;
      if (!done) check("run_reached_done", 32'(done), 32'd1);
   endtask

   initial begin
      for (int i = 0; i < 16; i++) regs[i] = 32'd0;
      for (int i = 0; i < 6; i++) regs[i+1] = exp_vals[i];
      repeat (3) @(negedge clk);
      check("rst_core_rst", 32'(core_rst), 32'd1);
      check("rst_core_en", 32'(core_en), 32'd0);
      check("rst_busy", 32'(busy), 32'd0);
      check("rst_done", 32'(done), 32'd0);
      check("rst_pass", 32'(pass), 32'd0);
      check("rst_timeout", 32'(timeout), 32'd0);
      check("rst_err_count", 32'(err_count), 32'd0);
      check("rst_fail_idx", 32'(fail_idx), 32'd0);
      check("rst_fail_data", fail_data, 32'd0);
      check("rst_cycle_count", 32'(cycle_count), 32'd0);
      check("rst_reg_addr", 32'(reg_addr), 32'd0);
      rst = 1'b1;
      for (int i = 0; i < 6; i++) load(i, i + 1, int'(exp_vals[i]));

      // all registers match, halt in RUN cycle 12
      do_run(12, 1'b0, 1'b0);
      check("match_pass", 32'(pass), 32'd1);
      check("match_err", 32'(err_count), 32'd0);
      check("match_timeout", 32'(timeout), 32'd0);
      check("match_cycles", 32'(cycle_count), 32'd12);
      check("match_check_len", 32'(chk_cyc), 32'd7);
      check("match_addr_cnt", 32'(addr_cnt), 32'd6);
      check("match_rst_fall", 32'(rst_fall), 32'd2);
      check("match_busy_done", 32'(both_hi), 32'd0);
      check("match_core_en_done", 32'(core_en), 32'd0);

      // r5 reads 7, r6 reads 0; back-to-back start from DONE
      regs[5] = 32'd7; regs[6] = 32'd0;
      do_run(12, 1'b0, 1'b0);
      check("mis_err", 32'(err_count), 32'd2);
      check("mis_fail_idx", 32'(fail_idx), 32'd4);
      check("mis_fail_data", fail_data, 32'd7);
      check("mis_pass", 32'(pass), 32'd0);
      check("mis_cycles", 32'(cycle_count), 32'd12);

      // halt never arrives: budget expires
      regs[5] = 32'd6; regs[6] = 32'd4;
      do_run(0, 1'b0, 1'b0);
      check("restart_err_clear", 32'(first_err), 32'd0);
      check("restart_cc_clear", 32'(first_cc), 32'd0);
      check("restart_done_clear", 32'(first_done), 32'd0);
      check("to_timeout", 32'(timeout), 32'd1);
      check("to_cycles", 32'(cycle_count), 32'd20);
      check("to_pass", 32'(pass), 32'd0);
      check("to_err", 32'(err_count), 32'd0);

      // halt coincides with the budget limit
      do_run(20, 1'b0, 1'b0);
      check("tie_timeout", 32'(timeout), 32'd0);
      check("tie_cycles", 32'(cycle_count), 32'd20);
      check("tie_pass", 32'(pass), 32'd1);

      // start and table write during RUN are ignored
      do_run(12, 1'b1, 1'b1);
      check("ign_cycles", 32'(cycle_count), 32'd12);
      check("ign_pass", 32'(pass), 32'd1);
      do_run(9, 1'b0, 1'b0);
      check("ign_next_pass", 32'(pass), 32'd1);
      check("ign_next_cycles", 32'(cycle_count), 32'd9);

      // sparse table: only entries 0 and 3
      @(negedge clk); rst = 1'b0;
      @(negedge clk); rst = 1'b1;
      load(0, 1, 2);
      load(3, 4, 2);
      regs[2] = 32'd55; regs[3] = 32'd55; regs[5] = 32'd55; regs[6] = 32'd55;
      do_run(12, 1'b0, 1'b0);
      check("sparse_pass", 32'(pass), 32'd1);
      check("sparse_addr_cnt", 32'(addr_cnt), 32'd2);
      check("sparse_check_len", 32'(chk_cyc), 32'd7);
      regs[4] = 32'd3;
      do_run(12, 1'b0, 1'b0);
      check("sparse_err", 32'(err_count), 32'd1);
      check("sparse_fail_idx", 32'(fail_idx), 32'd3);
      check("sparse_fail_data", fail_data, 32'd3);

      // reset asserted mid-RUN
      @(negedge clk); start = 1'b1;
      @(negedge clk); start = 1'b0;
      for (int g = 0; g < 20 && !core_en; g++) @(negedge clk);
      check("mid_run_entered", 32'(core_en), 32'd1);
      repeat (4) @(negedge clk);
      rst = 1'b0;
      @(negedge clk);
      check("midrst_core_rst", 32'(core_rst), 32'd1);
      check("midrst_core_en", 32'(core_en), 32'd0);
      check("midrst_busy", 32'(busy), 32'd0);
      check("midrst_done", 32'(done), 32'd0);
      check("midrst_err", 32'(err_count), 32'd0);
      check("midrst_fail_data", fail_data, 32'd0);
      check("midrst_cycles", 32'(cycle_count), 32'd0);
      rst = 1'b1;
      do_run(12, 1'b0, 1'b0);
      check("empty_pass", 32'(pass), 32'd1);
      check("empty_err", 32'(err_count), 32'd0);
      check("empty_addr_cnt", 32'(addr_cnt), 32'd0);

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
